// File: rtl/tdc_chain_ctrl.sv
// Measurement sequencer for a carry-chain tapped delay line: launches N shots,
// latches and popcounts each tap word, and returns the summed count with error flags.
module tdc_chain_ctrl #(
    parameter int TAPS     = 5,
    parameter int AVG_LOG2 = 3,
    parameter int SETTLE   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              chain_pulse,
    output logic                              chain_latch,
    input  logic [TAPS-1:0]                   chain_dat,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [$clog2(TAPS+1)+AVG_LOG2-1:0] res_data,
    output logic                              res_err,
    output logic                              res_sat
);

    localparam int CW     = $clog2(TAPS + 1);
    localparam int AW     = CW + AVG_LOG2;
    localparam int SHOT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int N      = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_LATCH,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [SET_W-1:0]    settle_cnt;
    logic [SHOT_W-1:0]   shot_cnt;
    logic [AW-1:0]       acc;
    logic                err;
    logic                sat;
    logic                settle_last;
    logic                shot_last;
    logic                handshake;
    logic                new_meas;

    function automatic logic [CW-1:0] popcount(input logic [TAPS-1:0] d);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < TAPS; i++) begin
            n = n + CW'(d[i]);
        end
        return n;
    endfunction

    // A clean code is 0..01..1; adding one to it yields a single set bit.
    function automatic logic is_thermo(input logic [TAPS-1:0] d);
        logic [TAPS:0] x;
        x = {1'b0, d};
        return ((x & (x + {{TAPS{1'b0}}, 1'b1})) == '0);
    endfunction

    assign settle_last = (settle_cnt == SET_W'(SETTLE - 1));
    assign shot_last   = (shot_cnt == SHOT_W'(N - 1));
    assign handshake   = res_valid && res_ready;
    assign new_meas    = (next_state == S_LAUNCH) && ((state == S_IDLE) || (state == S_DONE));

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (start) next_state = S_LAUNCH;
                S_LAUNCH:  next_state = S_SETTLE;
                S_SETTLE:  if (settle_last) next_state = S_LATCH;
                S_LATCH:   next_state = S_CAPTURE;
                S_CAPTURE: next_state = shot_last ? S_DONE : S_LAUNCH;
                S_DONE:    if (handshake) next_state = start ? S_LAUNCH : S_IDLE;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            chain_pulse <= 1'b0;
            chain_latch <= 1'b0;
            settle_cnt  <= '0;
            shot_cnt    <= '0;
            acc         <= '0;
            err         <= 1'b0;
            sat         <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
            res_sat     <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state == S_LAUNCH) || (next_state == S_SETTLE) ||
                           (next_state == S_LATCH)  || (next_state == S_CAPTURE);
            chain_pulse <= (next_state == S_LAUNCH);
            chain_latch <= (next_state == S_LATCH);

            if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            if (new_meas) begin
                acc      <= '0;
                shot_cnt <= '0;
                err      <= 1'b0;
                sat      <= 1'b0;
            end else if ((state == S_CAPTURE) && !abort) begin
                acc <= acc + AW'(popcount(chain_dat));
                err <= err | !is_thermo(chain_dat);
                sat <= sat | (chain_dat == '1);
                if (!shot_last) begin
                    shot_cnt <= shot_cnt + 1'b1;
                end
            end

            // The result registers load on the first DONE cycle and then hold until the next load.
            if (abort) begin
                res_valid <= 1'b0;
            end else if ((state == S_DONE) && !res_valid) begin
                res_valid <= 1'b1;
                res_data  <= acc;
                res_err   <= err;
                res_sat   <= sat;
            end else if (handshake) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdc_chain_ctrl.sv
// Directed testbench for tdc_chain_ctrl with TAPS=5, AVG_LOG2=3, SETTLE=2.
module tb_tdc_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       chain_pulse;
    logic       chain_latch;
    logic [4:0] chain_dat;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_data;
    logic       res_err;
    logic       res_sat;

    logic [4:0] shot_dat [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_chain_ctrl #(.TAPS(5), .AVG_LOG2(3), .SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .chain_pulse(chain_pulse),
        .chain_latch(chain_latch),
        .chain_dat  (chain_dat),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_sat    (res_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [4:0] w);
        for (int i = 0; i < 8; i++) shot_dat[i] = w;
    endtask

    // Starts a measurement and follows it to res_valid; cyc counts edges from the start edge.
    task automatic measure(input bit mid_start, output int lat, output int np, output int nl,
                           output int bad);
        int cyc;
        lat = 0; np = 0; nl = 0; bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (chain_pulse) begin
                if (np < 8) chain_dat = shot_dat[np];
                if ((cyc % 5) != 1) bad++;
                np++;
            end
            if (chain_latch) begin
                if ((cyc % 5) != 4) bad++;
                nl++;
            end
            if (res_valid) begin
                lat = cyc;
                break;
            end
            if (mid_start) start = (cyc == 10);
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int exp_data, input bit exp_err,
                                 input bit exp_sat, input bit mid_start);
        int lat, np, nl, bad;
        measure(mid_start, lat, np, nl, bad);
        check({tag, "_latency"}, lat, 42);
        check({tag, "_pulses"}, np, 8);
        check({tag, "_latches"}, nl, 8);
        check({tag, "_strobe_pos"}, bad, 0);
        check({tag, "_data"}, 32'(res_data), exp_data);
        check({tag, "_err"}, 32'(res_err), 32'(exp_err));
        check({tag, "_sat"}, 32'(res_sat), 32'(exp_sat));
    endtask

    initial begin
        int bad;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        chain_dat = 5'b00000;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_data", 32'(res_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Steady 3-tap code on every shot.
        fill(5'b00111);
        run_and_check("steady", 24, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset mid-SETTLE just after the launch pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_mid_pulse_seen", 32'(chain_pulse), 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_pulse", 32'(chain_pulse), 0);
        check("rst_mid_latch", 32'(chain_latch), 0);
        check("rst_mid_data", 32'(res_data), 0);
        check("rst_mid_flags", {30'd0, res_err, res_sat}, 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || chain_pulse || chain_latch || res_valid) bad++;
        end
        check("rst_release_idle", bad, 0);

        // Alternating clean codes, then a bubble on shot 4.
        for (int i = 0; i < 8; i++) shot_dat[i] = (i % 2 == 0) ? 5'b00001 : 5'b00111;
        run_and_check("alt", 16, 1'b0, 1'b0, 1'b0);
        tick();
        shot_dat[3] = 5'b01011;
        run_and_check("bubble", 16, 1'b1, 1'b0, 1'b0);
        tick();

        // One saturated shot.
        fill(5'b00000);
        shot_dat[2] = 5'b11111;
        run_and_check("sat", 5, 1'b0, 1'b1, 1'b0);
        tick();

        // Backpressure with a stray start while busy.
        res_ready = 1'b0;
        fill(5'b00011);
        run_and_check("bp", 16, 1'b0, 1'b0, 1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!res_valid || (res_data !== 6'd16)) bad++;
        end
        check("bp_stable", bad, 0);

        // start together with the handshake launches straight away.
        res_ready = 1'b1;
        fill(5'b00001);
        run_and_check("b2b", 8, 1'b0, 1'b0, 1'b0);
        tick();

        // Abort during the third shot's SETTLE.
        chain_dat = 5'b11111;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("abort_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_pulse", {30'd0, chain_pulse, chain_latch}, 0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (res_valid || busy || chain_pulse) bad++;
            tick();
        end
        check("abort_quiet", bad, 0);
        fill(5'b00011);
        run_and_check("post_abort", 16, 1'b0, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
